// File: rtl/scfifo_legacy_prefetch.sv
// scfifo_legacy_prefetch: turns a normal-mode FIFO read port into a valid/ready stream
// using a credit-limited prefetch buffer that has no combinational path from out_ready to fifo_rdreq.
module scfifo_legacy_prefetch #(
  parameter int WIDTH = 20,
  parameter int READ_LATENCY = 2,
  localparam int BUF_DEPTH = READ_LATENCY + 2,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             sclr,
  input  logic [WIDTH-1:0] fifo_q,
  input  logic             fifo_empty,
  output logic             fifo_rdreq,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count
);
  localparam int PW = $clog2(BUF_DEPTH);
  logic [READ_LATENCY-1:0] r_vld;
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [CW-1:0] w_inflight;
  logic w_cap, w_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_inflight = w_inflight + CW'(r_vld[i]);
  end
  assign w_cap = r_vld[READ_LATENCY-1];
  assign out_valid = r_cnt != '0;
  assign w_pop = out_valid && out_ready;
  assign out_count = r_cnt;
  assign out_data = r_mem[r_rd];
  // credit counts every word already requested, so a capture always has a free slot
  assign fifo_rdreq = !aclr && !sclr && !fifo_empty &&
                      ({1'b0, w_inflight} + {1'b0, r_cnt} < (CW+1)'(BUF_DEPTH));
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_vld <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (sclr) begin
      r_vld <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_vld <= READ_LATENCY'({r_vld, fifo_rdreq});
      r_wr <= w_cap ? nxt(r_wr) : r_wr;
      r_rd <= w_pop ? nxt(r_rd) : r_rd;
      r_cnt <= r_cnt + CW'(w_cap) - CW'(w_pop);
    end
  end
  always_ff @(posedge clock)
    if (w_cap && !sclr) r_mem[r_wr] <= fifo_q;
endmodule

// File: tb/tb_scfifo_legacy_prefetch.sv
// tb_scfifo_legacy_prefetch: directed vector table plus reset/throughput/random sequences,
// with a latency-2 upstream FIFO model and an in-order scoreboard.
module tb_scfifo_legacy_prefetch;
  localparam int W = 20;
  localparam int RL = 2;
  localparam logic [W-1:0] SENT = 20'hFFFFF;
  typedef struct {
    logic rdy;
    int npush;
    logic [W-1:0] base;
    logic ev;
    logic [2:0] ec;
    logic erq;
    logic [W-1:0] ed;
  } vec_t;
  logic clock = 1'b0, aclr = 1'b1, sclr = 1'b0, fifo_empty = 1'b1, out_ready = 1'b0;
  logic [W-1:0] fifo_q, out_data, up_w;
  logic fifo_rdreq, out_valid;
  logic [2:0] out_count;
  logic [W-1:0] pipe [RL];
  logic [W-1:0] up_q[$], exp_q[$];
  vec_t tbl [16];
  int checks = 0, failures = 0, cyc = 0, xfers = 0, seg_first = -1, seg_last = -1;
  int x0, pushed;
  always #5 clock = ~clock;
  scfifo_legacy_prefetch #(.WIDTH(W), .READ_LATENCY(RL)) dut (
    .clock(clock), .aclr(aclr), .sclr(sclr), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count)
  );
  assign fifo_q = pipe[RL-1];
  function automatic void eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
    end
  endfunction
  task automatic push(input logic [W-1:0] v, input bit track);
    up_q.push_back(v);
    if (track) exp_q.push_back(v);
  endtask
  initial for (int i = 0; i < RL; i++) pipe[i] = SENT;
  // upstream normal-mode FIFO: q is valid RL edges after the edge that sampled rdreq
  always @(posedge clock) begin
    up_w = SENT;
    if (sclr) up_q.delete();
    else if (fifo_rdreq && up_q.size() != 0) up_w = up_q.pop_front();
    pipe[0] <= up_w;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    fifo_empty <= up_q.size() == 0;
  end
  always @(posedge clock) begin
    cyc++;
    if (out_valid && out_ready) begin
      eq("xfer_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) eq("xfer_data", 32'(out_data), 32'(exp_q.pop_front()));
      xfers++;
      if (seg_first < 0) seg_first = cyc;
      seg_last = cyc;
    end
    eq("count_max", 32'(out_count <= 3'd4), 32'd1);
  end
  initial begin
    tbl[0]  = '{1'b1, 1,  20'h1, 1'b0, 3'd0, 1'b0, 20'h0};
    tbl[1]  = '{1'b1, 0,  20'h0, 1'b0, 3'd0, 1'b1, 20'h0};
    tbl[2]  = '{1'b1, 0,  20'h0, 1'b0, 3'd0, 1'b0, 20'h0};
    tbl[3]  = '{1'b1, 0,  20'h0, 1'b0, 3'd0, 1'b0, 20'h0};
    tbl[4]  = '{1'b1, 0,  20'h0, 1'b1, 3'd1, 1'b0, 20'h1};
    tbl[5]  = '{1'b1, 0,  20'h0, 1'b0, 3'd0, 1'b0, 20'h0};
    tbl[6]  = '{1'b0, 10, 20'h0, 1'b0, 3'd0, 1'b0, 20'h0};
    tbl[7]  = '{1'b0, 0,  20'h0, 1'b0, 3'd0, 1'b1, 20'h0};
    tbl[8]  = '{1'b0, 0,  20'h0, 1'b0, 3'd0, 1'b1, 20'h0};
    tbl[9]  = '{1'b0, 0,  20'h0, 1'b0, 3'd0, 1'b1, 20'h0};
    tbl[10] = '{1'b0, 0,  20'h0, 1'b1, 3'd1, 1'b1, 20'h0};
    tbl[11] = '{1'b0, 0,  20'h0, 1'b1, 3'd2, 1'b0, 20'h0};
    tbl[12] = '{1'b0, 0,  20'h0, 1'b1, 3'd3, 1'b0, 20'h0};
    tbl[13] = '{1'b0, 0,  20'h0, 1'b1, 3'd4, 1'b0, 20'h0};
    tbl[14] = '{1'b0, 0,  20'h0, 1'b1, 3'd4, 1'b0, 20'h0};
    tbl[15] = '{1'b1, 0,  20'h0, 1'b1, 3'd4, 1'b0, 20'h0};
    repeat (2) @(negedge clock);
    eq("rst_valid", 32'(out_valid), 32'd0);
    eq("rst_count", 32'(out_count), 32'd0);
    eq("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    aclr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      out_ready = tbl[i].rdy;
      for (int k = 0; k < tbl[i].npush; k++) push(tbl[i].base + W'(k), 1'b1);
      #1;
      eq($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      eq($sformatf("vec%0d_count", i), 32'(out_count), 32'(tbl[i].ec));
      eq($sformatf("vec%0d_rdreq", i), 32'(fifo_rdreq), 32'(tbl[i].erq));
      if (tbl[i].ev) eq($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
    end
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clock);
    eq("bp_drain", 32'(exp_q.size()), 32'd0);
    eq("bp_idle_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    seg_first = -1;
    x0 = xfers;
    for (int i = 0; i < 100; i++) push(W'(i), 1'b1);
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clock);
    eq("thr_xfers", 32'(xfers - x0), 32'd100);
    eq("thr_span", 32'(seg_last - seg_first), 32'd99);
    pushed = 0;
    for (int n = 0; n < 60000 && (pushed < 10000 || exp_q.size() != 0); n++) begin
      @(negedge clock);
      out_ready = 1'($urandom_range(0, 1));
      if (pushed < 10000 && $urandom_range(0, 9) < 6) begin
        push(W'($urandom), 1'b1);
        pushed++;
      end
    end
    eq("rand_pushed", 32'(pushed), 32'd10000);
    eq("rand_drain", 32'(exp_q.size()), 32'd0);
    repeat (6) @(negedge clock);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(W'(32'h100 + i), 1'b0);
    for (int n = 0; n < 20 && out_count != 3'd3; n++) @(negedge clock);
    eq("aclr_pre_count", 32'(out_count), 32'd3);
    aclr = 1'b1;
    up_q.delete();
    #1;
    eq("aclr_valid", 32'(out_valid), 32'd0);
    eq("aclr_count", 32'(out_count), 32'd0);
    eq("aclr_rdreq", 32'(fifo_rdreq), 32'd0);
    @(negedge clock);
    aclr = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clock);
      eq("aclr_stale", 32'(out_valid), 32'd0);
    end
    @(negedge clock);
    push(20'hABCDE, 1'b0);
    push(20'h12345, 1'b0);
    #1 eq("sclr_rdreq_idle", 32'(fifo_rdreq), 32'd0);
    @(negedge clock);
    #1 eq("sclr_rdreq_issue", 32'(fifo_rdreq), 32'd1);
    @(negedge clock);
    sclr = 1'b1;
    #1 eq("sclr_rdreq_hold", 32'(fifo_rdreq), 32'd0);
    @(negedge clock);
    sclr = 1'b0;
    #1;
    eq("sclr_valid", 32'(out_valid), 32'd0);
    eq("sclr_count", 32'(out_count), 32'd0);
    repeat (5) begin
      @(negedge clock);
      eq("sclr_stale", 32'(out_valid), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
